// File: rtl/adc_ctrl_pkg.sv
// Shared types and constants for the dual-ADC frame sequencer.
// States, slave register map and frame-length limit.
package adc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_IRQ,
        ST_DRAIN,
        ST_CLR,
        ST_CLR_REL,
        ST_NEXT,
        ST_STOP,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_START  = 2'd1;
    localparam logic [1:0] ADDR_CLRIRQ = 2'd2;

    localparam int FRAME_LEN_MAX = 4095;
    localparam int WCNT_W        = 12;

endpackage

// File: rtl/adc_seq_outreg.sv
// One-deep sample output register with read-issue gating.
// At most one read in flight; a read issues only when the slot frees up.
module adc_seq_outreg (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] rdata,
    input  logic        ready,
    output logic        rd,
    output logic [31:0] data,
    output logic        valid
);

    logic inflight;

    assign rd = en && !inflight && (!valid || ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            valid    <= 1'b0;
            data     <= '0;
        end else begin
            inflight <= rd;
            // read data is valid exactly one cycle after the strobe
            if (inflight) begin
                data  <= rdata;
                valid <= 1'b1;
            end else if (ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/adc_frame_sequencer.sv
// Avalon-MM master sequencing frame capture from the dual-ADC slave.
// Optional FRAME_CHECKSUM_EN adds a per-frame wrapping sum of samples.
module adc_frame_sequencer
    import adc_ctrl_pkg::*;
#(
    parameter int FRAME_LEN   = 1024,
    parameter int TIMEOUT_CYC = 1 << 20,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_frames,
    output logic [1:0]       m_address,
    output logic             m_write,
    output logic             m_read,
    output logic [31:0]      m_writedata,
    input  logic [31:0]      m_readdata,
    input  logic             irq,
    output logic [31:0]      s_data,
    output logic             s_valid,
    input  logic             s_ready,
    output logic             s_last,
`ifdef FRAME_CHECKSUM_EN
    output logic [31:0]      frame_sum,
    output logic             frame_sum_vld,
`endif
    output logic             busy,
    output logic             err_timeout,
    output logic [CNT_W-1:0] frames_done
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam int LEN_I = (FRAME_LEN > FRAME_LEN_MAX) ? FRAME_LEN_MAX : FRAME_LEN;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [WCNT_W-1:0] LEN      = WCNT_W'(LEN_I);
    localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(LEN_I - 1);

    state_t             state;
    state_t             nxt;
    logic [TMR_W-1:0]   timer;
    logic [WCNT_W-1:0]  issue_cnt;
    logic [WCNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]   frames_inc;
    logic               abort_pend;
    logic               go_ok;
    logic               beat;
    logic               frame_end;
    logic               run_end;
    logic               tmo;
    logic               rd_en;

    assign busy       = !(state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign go_ok      = go && !busy;
    assign beat       = s_valid && s_ready;
    assign frame_end  = beat && (word_cnt == LAST_IDX);
    assign s_last     = s_valid && (word_cnt == LAST_IDX);
    assign frames_inc = (&frames_done) ? frames_done : frames_done + 1'b1;
    assign run_end    = abort || abort_pend
                     || (cfg_frames != '0 && frames_inc == cfg_frames);
    assign tmo        = (state == ST_WAIT_IRQ) && !abort && !irq
                     && (timer == TMR_LAST);

    always_comb begin
        nxt         = state;
        m_write     = 1'b0;
        m_address   = ADDR_DATA;
        m_writedata = '0;
        rd_en       = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (go_ok) nxt = ST_ARM;
            end
            ST_ARM: begin
                m_write     = 1'b1;
                m_address   = ADDR_START;
                m_writedata = 32'd1;
                nxt         = ST_WAIT_IRQ;
            end
            ST_WAIT_IRQ: begin
                if (abort)    nxt = ST_STOP;
                else if (irq) nxt = ST_DRAIN;
                else if (tmo) nxt = ST_STOP;
            end
            ST_DRAIN: begin
                rd_en = (issue_cnt != LEN);
                if (frame_end) nxt = ST_CLR;
            end
            ST_CLR: begin
                m_write     = 1'b1;
                m_address   = ADDR_CLRIRQ;
                m_writedata = 32'd1;
                nxt         = ST_CLR_REL;
            end
            ST_CLR_REL: begin
                m_write   = 1'b1;
                m_address = ADDR_CLRIRQ;
                nxt       = ST_NEXT;
            end
            ST_NEXT: begin
                nxt = run_end ? ST_STOP : ST_WAIT_IRQ;
            end
            ST_STOP: begin
                m_write   = 1'b1;
                m_address = ADDR_START;
                nxt       = err_timeout ? ST_ERR : ST_DONE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            timer       <= '0;
            issue_cnt   <= '0;
            word_cnt    <= '0;
            frames_done <= '0;
            err_timeout <= 1'b0;
            abort_pend  <= 1'b0;
        end else begin
            state <= nxt;
            timer <= (state == ST_WAIT_IRQ && nxt == ST_WAIT_IRQ) ? timer + 1'b1 : '0;
            if (frame_end)   issue_cnt <= '0;
            else if (m_read) issue_cnt <= issue_cnt + 1'b1;
            if (frame_end)   word_cnt <= '0;
            else if (beat)   word_cnt <= word_cnt + 1'b1;
            if (go_ok)                 frames_done <= '0;
            else if (state == ST_NEXT) frames_done <= frames_inc;
            if (go_ok)    err_timeout <= 1'b0;
            else if (tmo) err_timeout <= 1'b1;
            // abort seen alongside go or mid-frame is held until the frame boundary
            if (go_ok)      abort_pend <= abort;
            else if (!busy) abort_pend <= 1'b0;
            else if (abort) abort_pend <= 1'b1;
        end
    end

    adc_seq_outreg u_outreg (
        .clk   (clk),
        .rst   (rst),
        .en    (rd_en),
        .rdata (m_readdata),
        .ready (s_ready),
        .rd    (m_read),
        .data  (s_data),
        .valid (s_valid)
    );

`ifdef FRAME_CHECKSUM_EN
    logic [31:0] sum;

    always_ff @(posedge clk) begin
        if (rst)                                       sum <= '0;
        else if (state == ST_ARM || state == ST_CLR_REL) sum <= '0;
        else if (beat)                                 sum <= sum + s_data;
    end

    assign frame_sum     = sum;
    assign frame_sum_vld = (state == ST_CLR);
`endif

endmodule
